// File: rtl/cake_spawn_sequencer.sv
// cake_spawn_sequencer
// Decides when a new cake spawns in CakeRain, either from a periodic spawn
// timer or from an explicit request. Each spawn reads the next random byte
// from rand_num_rom, scales it to a 10-bit screen x coordinate, and offers
// that coordinate to the cake-slot allocator over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   enable       game running; gates the spawn timer and new triggers
//   spawn_req    single-cycle explicit spawn request
//   rom_address  address to rand_num_rom (always the walk pointer)
//   rom_data     registered rand_num_rom output, 1-cycle read latency
//   spawn_valid  spawn_x is valid
//   spawn_x      spawn x coordinate = rom_data*4 + X_OFFSET
//   spawn_ready  allocator accepts spawn_x
//   spawn_count  number of accepted spawns (wraps)
module cake_spawn_sequencer #(
  parameter int ROM_LAST     = 144,
  parameter int SKIP_ADDR    = 111,
  parameter int SPAWN_PERIOD = 50000000,
  parameter int X_OFFSET     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        spawn_req,
  output logic [7:0]  rom_address,
  input  logic [7:0]  rom_data,
  output logic        spawn_valid,
  output logic [9:0]  spawn_x,
  input  logic        spawn_ready,
  output logic [15:0] spawn_count
);

  localparam int TW = $clog2(SPAWN_PERIOD);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, PRESENT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    ptr;
  logic [7:0]    ptr_inc;
  logic [7:0]    ptr_next;
  logic          pending;
  logic          tick;
  logic          trigger;

  assign tick        = enable && (timer == TW'(SPAWN_PERIOD - 1));
  // A request and a tick in the same cycle collapse into one trigger.
  assign trigger     = enable && (spawn_req || tick);
  assign rom_address = ptr;

  // Pointer walk: wrap after the last populated address, hop over the hole.
  always_comb begin
    ptr_inc  = (ptr == 8'(ROM_LAST)) ? 8'd0 : ptr + 8'd1;
    ptr_next = (ptr_inc == 8'(SKIP_ADDR)) ? 8'(SKIP_ADDR + 1) : ptr_inc;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) timer <= '0;
    else                          timer <= timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 8'd0;
      pending     <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_x     <= 10'd0;
      spawn_count <= 16'd0;
    end else begin
      // Triggers arriving mid-transaction are remembered once; more are lost.
      if (!enable)                        pending <= 1'b0;
      else if (state != IDLE && trigger)  pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger || (pending && enable)) begin
            state   <= FETCH;
            pending <= 1'b0;
          end
        end
        // ROM registers rom_address at the end of this cycle.
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          spawn_x     <= {rom_data, 2'b00} + 10'(X_OFFSET);
          spawn_valid <= 1'b1;
          ptr         <= ptr_next;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (spawn_ready) begin
            spawn_valid <= 1'b0;
            spawn_count <= spawn_count + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cake_spawn_sequencer.sv
// Testbench for cake_spawn_sequencer. A main instance with the default
// (very long) spawn period exercises the request path; a second instance
// with SPAWN_PERIOD=8 exercises the timer. Each has its own ROM model.
module tb_cake_spawn_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, spawn_req = 1'b0, spawn_ready = 1'b0;
  logic [7:0]  rom_address, rom_data;
  logic        spawn_valid;
  logic [9:0]  spawn_x;
  logic [15:0] spawn_count;

  logic        t_en = 1'b0;
  logic        t_req = 1'b0;
  logic        t_rdy = 1'b1;
  logic [7:0]  t_addr, t_data;
  logic        t_valid;
  logic [9:0]  t_x;
  logic [15:0] t_count;

  logic [7:0]  rom [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cake_spawn_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .spawn_req(spawn_req),
    .rom_address(rom_address), .rom_data(rom_data), .spawn_valid(spawn_valid),
    .spawn_x(spawn_x), .spawn_ready(spawn_ready), .spawn_count(spawn_count)
  );

  cake_spawn_sequencer #(.SPAWN_PERIOD(8)) dut_t (
    .clk(clk), .reset(reset), .enable(t_en), .spawn_req(t_req),
    .rom_address(t_addr), .rom_data(t_data), .spawn_valid(t_valid),
    .spawn_x(t_x), .spawn_ready(t_rdy), .spawn_count(t_count)
  );

  // Registered ROM models, one-cycle read latency.
  always_ff @(posedge clk) rom_data <= rom[rom_address];
  always_ff @(posedge clk) t_data   <= rom[t_addr];

  typedef struct {
    logic       rst, en, req, rdy;
    logic       v;
    int         x, a, c;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic rst, logic en, logic req, logic rdy,
                              logic v, int x, int a, int c);
    vec_t r;
    r.rst = rst; r.en = en; r.req = req; r.rdy = rdy;
    r.v = v; r.x = x; r.a = a; r.c = c;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; spawn_req = 1'b0; spawn_ready = 1'b0; t_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse spawn_req, wait (bounded) for spawn_valid, return x; ready must be 1
  // so the next edge accepts. Returns at the negedge after the accept.
  task automatic do_spawn(output int x);
    bit ok;
    ok = 1'b0;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (spawn_valid) begin ok = 1'b1; break; end
    end
    x = int'(spawn_x);
    check("spawn_timeout", int'(ok), 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, acc, lastx;
    bit stable;
    logic [32:0] mask;
    logic [32:0] exp_mask;

    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 7) % 149);
    rom[0] = 8'd73; rom[1] = 8'd95; rom[2] = 8'd71;
    rom[110] = 8'd88; rom[111] = 8'd200; rom[112] = 8'd20; rom[144] = 8'd91;

    //              rst en req rdy | v  x    addr cnt
    vecs[0]  = mk(1, 1, 1, 1,  0, 0,   0, 0);
    vecs[1]  = mk(1, 1, 1, 1,  0, 0,   0, 0);
    vecs[2]  = mk(1, 1, 1, 1,  0, 0,   0, 0);
    vecs[3]  = mk(0, 0, 0, 0,  0, 0,   0, 0);
    vecs[4]  = mk(0, 1, 1, 1,  0, 0,   0, 0);   // trigger -> FETCH, addr 0
    vecs[5]  = mk(0, 1, 0, 1,  0, 0,   0, 0);   // CAPTURE
    vecs[6]  = mk(0, 1, 0, 1,  1, 308, 1, 0);   // PRESENT at t+3
    vecs[7]  = mk(0, 1, 0, 1,  0, 308, 1, 1);   // accepted, one-cycle pulse
    vecs[8]  = mk(0, 1, 1, 1,  0, 308, 1, 1);
    vecs[9]  = mk(0, 1, 0, 1,  0, 308, 1, 1);
    vecs[10] = mk(0, 1, 0, 1,  1, 396, 2, 1);
    vecs[11] = mk(0, 1, 0, 1,  0, 396, 2, 2);
    vecs[12] = mk(0, 1, 1, 1,  0, 396, 2, 2);
    vecs[13] = mk(0, 1, 0, 1,  0, 396, 2, 2);
    vecs[14] = mk(0, 1, 0, 1,  1, 300, 3, 2);
    vecs[15] = mk(0, 1, 0, 1,  0, 300, 3, 3);
    vecs[16] = mk(0, 1, 0, 0,  0, 300, 3, 3);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; enable = vecs[i].en;
      spawn_req = vecs[i].req; spawn_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), int'(spawn_valid), int'(vecs[i].v));
      check($sformatf("vec%0d_x", i),     int'(spawn_x),     vecs[i].x);
      check($sformatf("vec%0d_addr", i),  int'(rom_address), vecs[i].a);
      check($sformatf("vec%0d_count", i), int'(spawn_count), vecs[i].c);
    end

    // Backpressure: held output, pending saturates at one extra spawn.
    apply_reset();
    enable = 1'b1; spawn_ready = 1'b0; spawn_req = 1'b1;
    @(negedge clk); spawn_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_first_valid", int'(spawn_valid), 1);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      spawn_req = (k == 1 || k == 4 || k == 7);
      @(negedge clk);
      if (!spawn_valid || spawn_x != 10'd308) stable = 1'b0;
    end
    check("bp_stable", int'(stable), 1);
    spawn_req = 1'b0; spawn_ready = 1'b1;
    acc = 0; lastx = 0;
    for (int k = 0; k < 20; k++) begin
      if (spawn_valid) begin acc++; lastx = int'(spawn_x); end
      @(negedge clk);
    end
    check("bp_accepts", acc, 2);
    check("bp_second_x", lastx, 396);
    check("bp_count", int'(spawn_count), 2);
    check("bp_addr", int'(rom_address), 2);

    // Dropping enable clears pending but lets the in-flight spawn finish.
    apply_reset();
    enable = 1'b1; spawn_ready = 1'b0; spawn_req = 1'b1;
    @(negedge clk); spawn_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    spawn_req = 1'b1;
    @(negedge clk); spawn_req = 1'b0;
    enable = 1'b0; spawn_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      if (spawn_valid) acc++;
      @(negedge clk);
    end
    check("en_drop_accepts", acc, 1);
    check("en_drop_count", int'(spawn_count), 1);

    // Reset during PRESENT discards the spawn.
    apply_reset();
    enable = 1'b1; spawn_ready = 1'b0; spawn_req = 1'b1;
    @(negedge clk); spawn_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_before", int'(spawn_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", int'(spawn_valid), 0);
    check("mid_rst_x", int'(spawn_x), 0);
    check("mid_rst_addr", int'(rom_address), 0);
    reset = 1'b0;

    // Walk the pointer across the hole at 111 and the wrap after 144.
    apply_reset();
    enable = 1'b1; spawn_ready = 1'b1;
    for (int k = 0; k < 110; k++) do_spawn(x);
    check("walk_addr110", int'(rom_address), 110);
    do_spawn(x);
    check("skip_x", x, 368);
    check("skip_addr", int'(rom_address), 112);
    do_spawn(x);
    check("after_skip_x", x, 96);
    check("after_skip_addr", int'(rom_address), 113);
    for (int k = 0; k < 31; k++) do_spawn(x);
    check("walk_addr144", int'(rom_address), 144);
    do_spawn(x);
    check("wrap_x", x, 380);
    check("wrap_addr", int'(rom_address), 0);
    check("wrap_count", int'(spawn_count), 144);

    // Timer instance: first spawn_valid in cycle 10 after enable, then every 8.
    exp_mask = '0;
    exp_mask[10] = 1'b1; exp_mask[18] = 1'b1; exp_mask[26] = 1'b1;
    apply_reset();
    t_en = 1'b1;
    mask = '0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (t_valid) mask[c] = 1'b1;
    end
    check("timer_mask", int'(mask[31:0]), int'(exp_mask[31:0]));
    check("timer_count", int'(t_count), 3);
    check("timer_last_x", int'(t_x), 300);

    // Enable drop at cycle 5 of a period: nothing while low, count restarts.
    apply_reset();
    t_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    t_en = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (t_valid) acc++;
    end
    check("timer_off_quiet", acc, 0);
    @(negedge clk);
    t_en = 1'b1;
    mask = '0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (t_valid) mask[c] = 1'b1;
    end
    check("timer_restart_mask", int'(mask[31:0]), int'(exp_mask[31:0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
